// File: rtl/mac_operand_sequencer_pkg.sv
// mac_operand_sequencer_pkg: shared FSM states, MAC timing constants and width helper.
`default_nettype none

package mac_operand_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FETCH = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Operand to out: product register, then accumulate.
  localparam int MAC_LATENCY  = 2;
  localparam int DRAIN_CYCLES = MAC_LATENCY + 1;

  function automatic int acc_width(input int width, input int length);
    return width + $clog2(length);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mac_operand_sequencer.sv
// mac_operand_sequencer: streams LENGTH operand pairs from two vector memories into
// an external mac and returns the dot product on a valid/ready port.
`default_nettype none

module mac_operand_sequencer
  import mac_operand_sequencer_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int LENGTH     = 3,
  parameter int ACC_WIDTH  = acc_width(WIDTH, LENGTH),
  parameter int ADDR_WIDTH = (LENGTH > 1) ? $clog2(LENGTH) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [WIDTH-1:0]      rd_data_a,
  input  logic [WIDTH-1:0]      rd_data_b,
  output logic                  mac_rst,
  output logic [WIDTH-1:0]      mac_a,
  output logic [WIDTH-1:0]      mac_b,
  input  logic [ACC_WIDTH-1:0]  mac_out,
  output logic [ACC_WIDTH-1:0]  result,
  output logic                  result_valid,
  input  logic                  result_ready
);

  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  state_t               state;
  state_t               state_next;
  logic [ADDR_WIDTH-1:0] idx;
  logic [DRAIN_W-1:0]   drain_cnt;
  logic                 op_valid;
  logic                 clear_mac;
  logic                 last_fetch;
  logic                 last_drain;

  assign last_fetch = (idx == ADDR_WIDTH'(LENGTH - 1));
  assign last_drain = (drain_cnt == DRAIN_W'(DRAIN_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      idx          <= '0;
      drain_cnt    <= '0;
      op_valid     <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      state    <= state_next;
      op_valid <= rd_en;
      case (state)
        CLEAR: idx <= '0;
        FETCH: begin
          idx <= idx + 1'b1;
          if (last_fetch) drain_cnt <= '0;
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + 1'b1;
          if (last_drain) begin
            result       <= mac_out;
            result_valid <= 1'b1;
          end
        end
        DONE: if (result_ready) result_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b1;
    rd_en      = 1'b0;
    clear_mac  = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = CLEAR;
      end
      CLEAR: begin
        clear_mac  = 1'b1;
        state_next = FETCH;
      end
      FETCH: begin
        rd_en = 1'b1;
        if (last_fetch) state_next = DRAIN;
      end
      DRAIN: if (last_drain) state_next = DONE;
      DONE:  if (result_valid && result_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign rd_addr = idx;
  // The mac must clear together with this block, so reset reaches it combinationally.
  assign mac_rst = clear_mac || !reset;
  assign mac_a   = op_valid ? rd_data_a : '0;
  assign mac_b   = op_valid ? rd_data_b : '0;

endmodule

`default_nettype wire

// File: tb/tb_mac_operand_sequencer.sv
// tb_mac_operand_sequencer: drives the sequencer with a memory and mac model and
// compares results against a plain dot-product reference.
`default_nettype none

module tb_mac_operand_sequencer;

  localparam int WIDTH  = 8;
  localparam int LENGTH = 3;
  localparam int ACC_W  = WIDTH + $clog2(LENGTH);
  localparam int ADDR_W = 2;
  localparam int LAT    = LENGTH + 5;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              busy;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [WIDTH-1:0]  rd_data_a = '0;
  logic [WIDTH-1:0]  rd_data_b = '0;
  logic              mac_rst;
  logic [WIDTH-1:0]  mac_a;
  logic [WIDTH-1:0]  mac_b;
  logic [ACC_W-1:0]  mac_out;
  logic [ACC_W-1:0]  result;
  logic              result_valid;
  logic              result_ready = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  logic [WIDTH-1:0] mem_a [LENGTH];
  logic [WIDTH-1:0] mem_b [LENGTH];
  logic             tr_rst  [64];
  logic             tr_en   [64];
  logic [ADDR_W-1:0] tr_addr [64];

  mac_operand_sequencer #(.WIDTH(WIDTH), .LENGTH(LENGTH)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .mac_rst(mac_rst), .mac_a(mac_a), .mac_b(mac_b), .mac_out(mac_out),
    .result(result), .result_valid(result_valid), .result_ready(result_ready)
  );

  always #5 clk = ~clk;

  // Synchronous-read memories; junk data outside reads exercises operand gating.
  always @(posedge clk) begin
    if (rd_en) begin
      rd_data_a <= mem_a[rd_addr];
      rd_data_b <= mem_b[rd_addr];
    end else begin
      rd_data_a <= WIDTH'($urandom_range(1, 255));
      rd_data_b <= WIDTH'($urandom_range(1, 255));
    end
  end

  // External mac: registered product, then accumulate.
  logic [2*WIDTH-1:0] mac_prod = '0;
  logic [ACC_W-1:0]   mac_acc  = '0;
  always @(posedge clk) begin
    if (mac_rst) begin
      mac_prod <= '0;
      mac_acc  <= '0;
    end else begin
      mac_prod <= mac_a * mac_b;
      mac_acc  <= mac_acc + ACC_W'(mac_prod);
    end
  end
  assign mac_out = mac_acc;

  function automatic logic [ACC_W-1:0] ref_dot();
    longint s = 0;
    for (int i = 0; i < LENGTH; i++) s += longint'(mem_a[i]) * longint'(mem_b[i]);
    return ACC_W'(s % (longint'(1) << ACC_W));
  endfunction

  task automatic load(input int a0, a1, a2, b0, b1, b2);
    mem_a[0] = WIDTH'(a0); mem_a[1] = WIDTH'(a1); mem_a[2] = WIDTH'(a2);
    mem_b[0] = WIDTH'(b0); mem_b[1] = WIDTH'(b1); mem_b[2] = WIDTH'(b2);
  endtask

  // Called at a negedge in IDLE; returns at the negedge where result_valid is first seen.
  task automatic run_dot(output logic [ACC_W-1:0] res, output int lat);
    res = '0;
    lat = -1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c < 40; c++) begin
      tr_rst[c] = mac_rst; tr_en[c] = rd_en; tr_addr[c] = rd_addr;
      if (result_valid) begin
        lat = c;
        res = result;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %0b want 0", busy); end
    n_vec++; if (rd_en !== 1'b0) begin n_err++; $display("FAIL reset_rd_en got %0b want 0", rd_en); end
    n_vec++; if (result_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0b want 0", result_valid); end
    n_vec++; if (result !== '0) begin n_err++; $display("FAIL reset_result got %0d want 0", result); end
    n_vec++; if (mac_rst !== 1'b1) begin n_err++; $display("FAIL reset_mac_rst got %0b want 1", mac_rst); end
    n_vec++; if (mac_a !== '0 || mac_b !== '0) begin n_err++; $display("FAIL reset_operands got %0d/%0d want 0/0", mac_a, mac_b); end
    reset = 1'b1;
    @(negedge clk);
    n_vec++; if (mac_rst !== 1'b0) begin n_err++; $display("FAIL idle_mac_rst got %0b want 0", mac_rst); end
  endtask

  task automatic test_basic();
    logic [ACC_W-1:0] res; int lat;
    load(1, 2, 3, 4, 5, 6);
    result_ready = 1'b1;
    run_dot(res, lat);
    n_vec++; if (lat !== LAT) begin n_err++; $display("FAIL basic_latency got %0d want %0d", lat, LAT); end
    n_vec++; if (res !== ACC_W'(32)) begin n_err++; $display("FAIL basic_result got %0d want 32", res); end
    if (lat >= LAT) begin
      n_vec++; if (tr_rst[1] !== 1'b1) begin n_err++; $display("FAIL basic_clear got %0b want 1", tr_rst[1]); end
      for (int c = 2; c <= 4; c++) begin
        n_vec++;
        if (tr_en[c] !== 1'b1 || tr_addr[c] !== ADDR_W'(c - 2)) begin
          n_err++; $display("FAIL basic_fetch c%0d got en=%0b addr=%0d want en=1 addr=%0d", c, tr_en[c], tr_addr[c], c - 2);
        end
      end
      n_vec++; if (tr_en[5] !== 1'b0) begin n_err++; $display("FAIL basic_drain_en got %0b want 0", tr_en[5]); end
    end
    @(negedge clk);
    n_vec++; if (busy !== 1'b0 || result_valid !== 1'b0) begin n_err++; $display("FAIL basic_return got busy=%0b valid=%0b want 0/0", busy, result_valid); end
  endtask

  task automatic test_backpressure();
    logic [ACC_W-1:0] res; int lat;
    load(1, 2, 3, 4, 5, 6);
    result_ready = 1'b0;
    run_dot(res, lat);
    n_vec++; if (res !== ACC_W'(32) || lat !== LAT) begin n_err++; $display("FAIL bp_first got %0d@%0d want 32@%0d", res, lat, LAT); end
    for (int i = 0; i < 10; i++) begin
      start = (i == 4);
      @(negedge clk);
      n_vec++;
      if (result !== ACC_W'(32) || result_valid !== 1'b1) begin
        n_err++; $display("FAIL bp_hold %0d got %0d valid=%0b want 32 valid=1", i, result, result_valid);
      end
    end
    result_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_vec++; if (result_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL bp_handshake got valid=%0b busy=%0b want 0/0", result_valid, busy); end
    n_vec++; if (result !== ACC_W'(32)) begin n_err++; $display("FAIL bp_result_kept got %0d want 32", result); end
    @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL bp_start_ignored got busy=%0b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [ACC_W-1:0] res; int lat;
    result_ready = 1'b1;
    load(1, 1, 1, 1, 1, 1);
    run_dot(res, lat);
    n_vec++; if (res !== ACC_W'(3) || lat !== LAT) begin n_err++; $display("FAIL b2b_first got %0d@%0d want 3@%0d", res, lat, LAT); end
    @(negedge clk);
    load(2, 0, 1, 3, 9, 2);
    run_dot(res, lat);
    n_vec++; if (res !== ACC_W'(8) || lat !== LAT) begin n_err++; $display("FAIL b2b_second got %0d@%0d want 8@%0d", res, lat, LAT); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_fetch();
    logic [ACC_W-1:0] res; int lat; bit hit;
    load(7, 7, 7, 7, 7, 7);
    result_ready = 1'b1;
    hit = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 10 && !hit; c++) begin
      if (rd_en && rd_addr == ADDR_W'(1)) hit = 1'b1;
      else @(negedge clk);
    end
    n_vec++; if (!hit) begin n_err++; $display("FAIL rst_mid_reach got none want rd_addr=1"); end
    reset = 1'b0;
    #1;
    n_vec++; if (mac_rst !== 1'b1) begin n_err++; $display("FAIL rst_mid_mac_rst got %0b want 1", mac_rst); end
    @(negedge clk);
    reset = 1'b1;
    n_vec++; if (busy !== 1'b0 || result_valid !== 1'b0 || rd_en !== 1'b0) begin
      n_err++; $display("FAIL rst_mid_idle got busy=%0b valid=%0b en=%0b want 0/0/0", busy, result_valid, rd_en);
    end
    @(negedge clk);
    load(1, 2, 3, 4, 5, 6);
    run_dot(res, lat);
    n_vec++; if (res !== ACC_W'(32) || lat !== LAT) begin n_err++; $display("FAIL rst_mid_rerun got %0d@%0d want 32@%0d", res, lat, LAT); end
    @(negedge clk);
  endtask

  task automatic test_operand_gating();
    logic prev_en; logic [ADDR_W-1:0] prev_addr; logic [WIDTH-1:0] ea, eb; bit done;
    load(5, 6, 7, 8, 9, 10);
    result_ready = 1'b1;
    prev_en = rd_en; prev_addr = rd_addr; done = 1'b0;
    start = 1'b1;
    for (int c = 0; c < 14 && !done; c++) begin
      @(negedge clk);
      start = 1'b0;
      ea = prev_en ? mem_a[prev_addr] : '0;
      eb = prev_en ? mem_b[prev_addr] : '0;
      n_vec++;
      if (mac_a !== ea || mac_b !== eb) begin
        n_err++; $display("FAIL gating c%0d got %0d/%0d want %0d/%0d", c, mac_a, mac_b, ea, eb);
      end
      if (result_valid) begin
        done = 1'b1;
        n_vec++; if (result !== ref_dot()) begin n_err++; $display("FAIL gating_result got %0d want %0d", result, ref_dot()); end
      end
      prev_en = rd_en; prev_addr = rd_addr;
    end
    n_vec++; if (!done) begin n_err++; $display("FAIL gating_timeout got no result want result_valid"); end
    @(negedge clk);
  endtask

  task automatic test_wrap();
    logic [ACC_W-1:0] res; int lat;
    load(255, 255, 255, 255, 255, 255);
    result_ready = 1'b1;
    run_dot(res, lat);
    n_vec++; if (res !== ACC_W'(515)) begin n_err++; $display("FAIL wrap got %0d want 515", res); end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [ACC_W-1:0] res, exp_res; int lat, wait_cycles;
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < LENGTH; i++) begin
        mem_a[i] = WIDTH'($urandom);
        mem_b[i] = WIDTH'($urandom);
      end
      exp_res = ref_dot();
      wait_cycles = $urandom_range(0, 4);
      result_ready = (wait_cycles == 0);
      run_dot(res, lat);
      n_vec++;
      if (res !== exp_res || lat !== LAT) begin
        n_err++; $display("FAIL random %0d got %0d@%0d want %0d@%0d", t, res, lat, exp_res, LAT);
      end
      repeat (wait_cycles) @(negedge clk);
      result_ready = 1'b1;
      @(negedge clk);
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL random_idle %0d got busy=%0b want 0", t, busy); end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    for (int i = 0; i < LENGTH; i++) begin mem_a[i] = '0; mem_b[i] = '0; end
    @(negedge clk);
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_fetch();
    test_operand_gating();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/mac_operand_sequencer.md
Name: mac_operand_sequencer

Overview:
Producer-side controller for the multiplier accumulator (mac). On a start pulse it clears the MAC and reads LENGTH operand pairs from two synchronous-read vector memories. It streams those pairs into the MAC's a/b inputs, gates the operands to zero outside valid beats, and waits out the MAC pipeline. It then captures the accumulated dot product and offers it on a valid/ready result port.

Parameters:
WIDTH, 8, operand width; matches the mac WIDTH.
LENGTH, 3, dot-product vector length; must be >= 1; matches the mac ACCUMULATIONS.
ACC_WIDTH, WIDTH + $clog2(LENGTH), width of the mac out and of result.
ADDR_WIDTH, max(1, $clog2(LENGTH)), operand memory address width.

Ports:
clk  in  1  clock.
reset  in  1  synchronous, active-low reset.
start  in  1  one-cycle request to begin a dot product; sampled only in IDLE.
busy  out  1  high in every state except IDLE.
rd_en  out  1  operand memory read enable.
rd_addr  out  ADDR_WIDTH  element index, shared by both operand memories.
rd_data_a  in  WIDTH  memory A data; valid 1 cycle after rd_en.
rd_data_b  in  WIDTH  memory B data; valid 1 cycle after rd_en.
mac_rst  out  1  active-high clear to the mac reset input.
mac_a  out  WIDTH  operand to the mac a input.
mac_b  out  WIDTH  operand to the mac b input.
mac_out  in  ACC_WIDTH  mac accumulator output.
result  out  ACC_WIDTH  captured dot product.
result_valid  out  1  result is available.
result_ready  in  1  consumer accepts the result.

Behaviour:
- Reset (reset==0 at a clk edge):
  - state goes to IDLE; idx, drain count and op_valid go to 0.
  - result and result_valid go to 0.
  - mac_rst is driven 1 combinationally whenever reset==0, so the MAC also clears.
  - Reset mid-operation aborts with no result produced.
- Operand gating: op_valid is rd_en delayed one cycle.
  - mac_a = op_valid ? rd_data_a : 0; likewise mac_b.
  - Zero operands keep the MAC adding 0 outside the valid beats.
- IDLE: busy=0, rd_en=0, mac_rst=0. If start==1, go to CLEAR.
- CLEAR (1 cycle): mac_rst=1, idx<=0, then go to FETCH.
- FETCH (LENGTH cycles): rd_en=1, rd_addr=idx, idx increments each cycle.
  - When idx==LENGTH-1, go to DRAIN with drain count 0.
- DRAIN (3 cycles): rd_en=0.
  - The MAC latency is 2 edges from operand to out (product_reg, then accumulate), so out settles after 2 cycles; the 3rd cycle samples it.
  - On the 3rd drain cycle, result<=mac_out, result_valid<=1, go to DONE.
- DONE: result and result_valid are held stable until result_valid && result_ready at an edge.
  - That edge clears result_valid and returns to IDLE; result keeps its value.
  - start is ignored in DONE, including the handshake cycle.
- start while busy: ignored, no effect.
- Latency: start sampled in cycle 0 gives result_valid first high in cycle LENGTH+5 (cycle 8 for LENGTH=3). Throughput is one dot product per LENGTH+6 cycles with result_ready held high.
- Arithmetic: all accumulation happens in the mac. result is mac_out verbatim, i.e. the sum of products modulo 2^ACC_WIDTH. No saturation.

Decomposition:
- Shared package holds:
  - state enum (IDLE, CLEAR, FETCH, DRAIN, DONE);
  - MAC_LATENCY = 2;
  - DRAIN_CYCLES = MAC_LATENCY + 1;
  - function computing ACC_WIDTH, reused by the mac instantiation.
- No sub-module. The mac is instantiated beside this block by the parent, not inside it.

Test Plan:
- Basic dot product:
  - Stimulus: A=[1,2,3], B=[4,5,6], start pulse in cycle 0.
  - Response: mac_rst high in cycle 1; rd_addr 0,1,2 in cycles 2-4; result_valid high in cycle 8 with result=32.
- Backpressure:
  - Stimulus: A=[1,2,3], B=[4,5,6]; result_ready held low 10 cycles after valid.
  - Response: result stays 32 and result_valid stays 1; a second start pulse in DONE is ignored. Raising ready causes one handshake, then IDLE.
- Back-to-back runs:
  - Stimulus: first vectors A=[1,1,1], B=[1,1,1], then A=[2,0,1], B=[3,9,2].
  - Response: results 3 then 8; the second result is unaffected by the first, proving the CLEAR.
- Reset mid-FETCH:
  - Stimulus: reset low for 1 cycle at rd_addr=1.
  - Response: state returns to IDLE, busy=0, mac_rst=1 during reset, result_valid=0. A following start with A=[1,2,3], B=[4,5,6] gives 32.
- Operand gating:
  - Stimulus: hold rd_data_a/b at nonzero values outside FETCH.
  - Response: mac_a and mac_b are 0 in every non-op_valid cycle; result is unchanged.
- Wrap:
  - Stimulus: A=[255,255,255], B=[255,255,255].
  - Response: result = 195075 mod 1024 = 515.
